// File: rtl/i2c_slave.sv
// I2C target answering one 7-bit address; oversamples SCL/SDA on clk, open-drain SDA, no clock stretching.
// Optional glitch filter on both lines when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h42,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rw,
    output logic       busy,
    output logic       done,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_RX_BYTE  = 3'd3,
        ST_RX_ACK   = 3'd4,
        ST_TX_BYTE  = 3'd5,
        ST_TX_ACK   = 3'd6
    } state_t;

    if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("FILTER_LEN must be within 2..15");
    end

    logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic r_scl_d, r_sda_d;
    logic w_scl, w_sda;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= scl_in;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic       r_scl_f, r_sda_f;
    logic [3:0] r_scl_cnt, r_sda_cnt;

    // Filtered value follows the synchronized one only after FILTER_LEN consecutive differing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_f   <= 1'b1;
            r_sda_f   <= 1'b1;
            r_scl_cnt <= 4'd0;
            r_sda_cnt <= 4'd0;
        end else begin
            if (r_scl_s2 != r_scl_f) begin
                if (r_scl_cnt == 4'(FILTER_LEN - 1)) begin
                    r_scl_f   <= r_scl_s2;
                    r_scl_cnt <= 4'd0;
                end else begin
                    r_scl_cnt <= r_scl_cnt + 4'd1;
                end
            end else begin
                r_scl_cnt <= 4'd0;
            end
            if (r_sda_s2 != r_sda_f) begin
                if (r_sda_cnt == 4'(FILTER_LEN - 1)) begin
                    r_sda_f   <= r_sda_s2;
                    r_sda_cnt <= 4'd0;
                end else begin
                    r_sda_cnt <= r_sda_cnt + 4'd1;
                end
            end else begin
                r_sda_cnt <= 4'd0;
            end
        end
    end

    assign w_scl = r_scl_f;
    assign w_sda = r_sda_f;
`else
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    state_t     r_state, w_state;
    logic [2:0] r_cnt, w_cnt;
    logic [7:0] r_shift, w_shift, r_rx_data, w_rx_data;
    logic       r_rx_valid, w_rx_valid, r_tx_req, w_tx_req, r_rw, w_rw;
    logic       r_busy, w_busy, r_done, w_done, r_sda_oe, w_sda_oe;
    logic       r_txn, w_txn, r_ld_pend, w_ld_pend;
    logic [7:0] w_byte;

    assign w_byte = {r_shift[6:0], w_sda};

    // In the ACK states, sda_oe itself marks whether the ACK slot has begun (set on its leading fall).
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_shift    = r_shift;
        w_rx_data  = r_rx_data;
        w_rx_valid = 1'b0;
        w_tx_req   = 1'b0;
        w_rw       = r_rw;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_sda_oe   = r_sda_oe;
        w_txn      = r_txn;
        w_ld_pend  = r_ld_pend;
        if (w_stop) begin
            w_state   = ST_IDLE;
            w_sda_oe  = 1'b0;
            w_busy    = 1'b0;
            w_done    = r_txn;
            w_txn     = 1'b0;
            w_ld_pend = 1'b0;
        end else if (w_start) begin
            w_state   = ST_ADDR;
            w_cnt     = 3'd0;
            w_sda_oe  = 1'b0;
            w_busy    = 1'b0;
            w_txn     = 1'b0;
            w_ld_pend = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: if (w_scl_rise) begin
                    w_shift = w_byte;
                    w_cnt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_cnt = 3'd0;
                        if (w_byte[7:1] == SLAVE_ADDR) begin
                            w_rw    = w_byte[0];
                            w_busy  = 1'b1;
                            w_txn   = 1'b1;
                            w_state = ST_ADDR_ACK;
                        end else begin
                            w_state = ST_IDLE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_rise && r_sda_oe && r_rw) begin
                        w_tx_req = 1'b1;
                    end else if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe = 1'b1;
                        end else if (r_rw) begin
                            w_shift  = tx_data;
                            w_sda_oe = ~tx_data[7];
                            w_cnt    = 3'd0;
                            w_state  = ST_TX_BYTE;
                        end else begin
                            w_sda_oe = 1'b0;
                            w_cnt    = 3'd0;
                            w_state  = ST_RX_BYTE;
                        end
                    end
                end
                ST_RX_BYTE: if (w_scl_rise) begin
                    w_shift = w_byte;
                    w_cnt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_cnt      = 3'd0;
                        w_rx_data  = w_byte;
                        w_rx_valid = 1'b1;
                        w_state    = ST_RX_ACK;
                    end
                end
                ST_RX_ACK: if (w_scl_fall) begin
                    if (!r_sda_oe) begin
                        w_sda_oe = 1'b1;
                    end else begin
                        w_sda_oe = 1'b0;
                        w_cnt    = 3'd0;
                        w_state  = ST_RX_BYTE;
                    end
                end
                // Counter wraps to 0 after the 8th rise, so a fall seen with r_cnt==0 ends the byte.
                ST_TX_BYTE: begin
                    if (w_scl_rise) begin
                        w_cnt = r_cnt + 3'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 3'd0) begin
                            w_sda_oe  = 1'b0;
                            w_ld_pend = 1'b0;
                            w_state   = ST_TX_ACK;
                        end else begin
                            w_shift  = {r_shift[6:0], 1'b0};
                            w_sda_oe = ~r_shift[6];
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (w_scl_rise && !r_ld_pend) begin
                        if (!w_sda) begin
                            w_tx_req  = 1'b1;
                            w_ld_pend = 1'b1;
                        end else begin
                            w_sda_oe = 1'b0;
                            w_busy   = 1'b0;
                            w_state  = ST_IDLE;
                        end
                    end else if (w_scl_fall && r_ld_pend) begin
                        w_shift   = tx_data;
                        w_sda_oe  = ~tx_data[7];
                        w_cnt     = 3'd0;
                        w_ld_pend = 1'b0;
                        w_state   = ST_TX_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_cnt      <= 3'd0;
            r_shift    <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_rw       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_txn      <= 1'b0;
            r_ld_pend  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
            r_cnt      <= w_cnt;
            r_shift    <= w_shift;
            r_rx_data  <= w_rx_data;
            r_rx_valid <= w_rx_valid;
            r_tx_req   <= w_tx_req;
            r_rw       <= w_rw;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_sda_oe   <= w_sda_oe;
            r_txn      <= w_txn;
            r_ld_pend  <= w_ld_pend;
        end
    end

    assign sda_out     = 1'b0;
    assign sda_oe      = r_sda_oe;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_req      = r_tx_req;
    assign rw          = r_rw;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged I2C master, user-side tx responder, rx scoreboard.
module tb_i2c_slave;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_in, sda_in, sda_out, sda_oe;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, tx_req, rw, busy, done;
    logic [2:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int n_rxv = 0, n_txr = 0, n_done = 0, n_oe = 0, n_addr = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    assign scl_in = m_scl;
    assign sda_in = m_sda & ~sda_oe;

    initial tx_data = 8'h00;

    i2c_slave #(.SLAVE_ADDR(7'h42), .FILTER_LEN(4)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
        .sda_out(sda_out), .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_req(tx_req), .rw(rw), .busy(busy), .done(done),
        .o_dbg_state(dbg_state)
    );

    // Monitor and user-side responder: collects rx bytes, counts pulse cycles, serves tx_data.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                n_rxv++;
                got_q.push_back(rx_data);
            end
            if (tx_req) begin
                n_txr++;
                tx_data = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hEE;
            end
            if (done) n_done++;
            if (sda_oe) n_oe++;
            if (dbg_state == 3'd1) n_addr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b0; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b1; qwait();
        qwait();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    qwait();
        m_scl = 1'b1; qwait(); qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        b = sda_in;   qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~master_ack);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_rx_cnt"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_rx_data"}, {24'h0, got_q.pop_front()}, {24'h0, exp_q.pop_front()});
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int b_rxv, b_txr, b_done, b_oe, b_addr;

        repeat (5) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_sda_out", sda_out, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_pulses", {rx_valid, tx_req, done}, 3'b000);
        check("rst_rw_busy", {rw, busy}, 2'b00);
        check("rst_state", dbg_state, 3'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Write 0xA5, 0x3C to 0x42
        b_rxv = n_rxv; b_done = n_done;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        bus_start();
        write_byte(8'h84, ack); check("w_addr_ack", ack, 0);
        check("w_busy", busy, 1);
        write_byte(8'hA5, ack); check("w_b1_ack", ack, 0);
        write_byte(8'h3C, ack); check("w_b2_ack", ack, 0);
        check("w_rw", rw, 0);
        bus_stop();
        check("w_rx_pulses", n_rxv - b_rxv, 2);
        check("w_rx_last", rx_data, 8'h3C);
        check("w_done", n_done - b_done, 1);
        check("w_busy_end", busy, 0);
        check_rx("w");

        // Wrong address 0x43
        b_rxv = n_rxv; b_done = n_done; b_oe = n_oe;
        bus_start();
        write_byte(8'h86, ack); check("na_addr_nack", ack, 1);
        check("na_busy", busy, 0);
        write_byte(8'hFF, ack); check("na_b1_nack", ack, 1);
        bus_stop();
        check("na_oe_cycles", n_oe - b_oe, 0);
        check("na_rx", n_rxv - b_rxv, 0);
        check("na_done", n_done - b_done, 0);
        check("na_state", dbg_state, 3'd0);

        // Read 0x96, 0x0F from 0x42; ACK first, NACK second
        b_txr = n_txr; b_done = n_done;
        tx_q.push_back(8'h96); tx_q.push_back(8'h0F);
        bus_start();
        write_byte(8'h85, ack); check("r_addr_ack", ack, 0);
        check("r_rw", rw, 1);
        read_byte(1'b1, rd); check("r_b1", rd, 8'h96);
        read_byte(1'b0, rd); check("r_b2", rd, 8'h0F);
        check("r_oe_after_nack", sda_oe, 0);
        check("r_busy_after_nack", busy, 0);
        check("r_tx_req", n_txr - b_txr, 2);
        bus_stop();
        check("r_done", n_done - b_done, 1);

        // Write 0x10, repeated START, read 0x55
        b_done = n_done;
        exp_q.push_back(8'h10);
        tx_q.push_back(8'h55);
        bus_start();
        write_byte(8'h84, ack); check("rs_addr_ack", ack, 0);
        write_byte(8'h10, ack); check("rs_b1_ack", ack, 0);
        bus_start();
        check("rs_busy_clr", busy, 0);
        check("rs_state_addr", dbg_state, 3'd1);
        write_byte(8'h85, ack); check("rs_raddr_ack", ack, 0);
        check("rs_rw", rw, 1);
        read_byte(1'b0, rd); check("rs_rd", rd, 8'h55);
        bus_stop();
        check("rs_rx_data", rx_data, 8'h10);
        check("rs_done", n_done - b_done, 1);
        check_rx("rs");

        // Reset during bit 4 of a read returning 0x00
        tx_q.push_back(8'h00);
        bus_start();
        write_byte(8'h85, ack); check("rr_addr_ack", ack, 0);
        for (int i = 0; i < 3; i++) begin
            read_bit(ack);
            check("rr_bit", ack, 0);
        end
        m_sda = 1'b1; qwait();
        m_scl = 1'b1;
        repeat (3) @(negedge clk);
        check("rr_oe_before", sda_oe, 1);
        #2 rst = 1'b1;
        #1 check("rr_oe_async", sda_oe, 0);
        @(negedge clk);
        check("rr_rw_busy", {rw, busy}, 2'b00);
        check("rr_rx_data", rx_data, 8'h00);
        check("rr_state", dbg_state, 3'd0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        b_done = n_done;
        bus_start();
        check("rr_restart_state", dbg_state, 3'd1);
        write_byte(8'h84, ack); check("rr_restart_ack", ack, 0);
        bus_stop();
        check("rr_restart_done", n_done - b_done, 1);

        // 2-cycle SDA low glitch with SCL high
        repeat (10) @(negedge clk);
        b_addr = n_addr;
        m_sda = 1'b0;
        repeat (2) @(negedge clk);
        m_sda = 1'b1;
        repeat (20) @(negedge clk);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        check("gl_start_seen", (n_addr - b_addr) > 0, 0);
`else
        check("gl_start_seen", (n_addr - b_addr) > 0, 1);
`endif
        check("gl_state_end", dbg_state, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
